// File: rtl/sdram_pkg.sv
// sdram_pkg: shared types, command encodings and timing for the SDRAM
// command sequencer.
// Build option: SDRAM_FASTINIT_EN shortens the power-up NOP wait to 16 cycles.
package sdram_pkg;

  typedef logic [11:0] cnt_t;

  typedef enum logic [3:0] {
    INIT_WAIT,
    INIT_PRE,
    INIT_REF,
    INIT_MRS,
    IDLE,
    ACT,
    RW,
    WAIT,
    REF
  } state_t;

  // {nCS, nRAS, nCAS, nWE}
  typedef enum logic [3:0] {
    CMD_MRS = 4'b0000,
    CMD_REF = 4'b0001,
    CMD_PRE = 4'b0010,
    CMD_ACT = 4'b0011,
    CMD_WR  = 4'b0100,
    CMD_RD  = 4'b0101,
    CMD_NOP = 4'b0111
  } cmd_t;

`ifdef SDRAM_FASTINIT_EN
  localparam int unsigned INIT_WAIT_CYCLES = 16;
`else
  localparam int unsigned INIT_WAIT_CYCLES = 2500;
`endif

  localparam int unsigned REF_INTERVAL = 195;
  localparam int unsigned CAS_LATENCY  = 2;

  // Cycle budgets of the multi-cycle states (command cycle included).
  localparam int unsigned PRE_CYCLES  = 2;  // PRE + 1 NOP
  localparam int unsigned REF_CYCLES  = 3;  // REF + 2 NOP
  localparam int unsigned MRS_CYCLES  = 3;  // MRS + 2 NOP
  localparam int unsigned ACT_CYCLES  = 2;  // ACT + 1 NOP
  localparam int unsigned WAIT_CYCLES = 3;  // NOPs after RD/WR

  // Burst length 1, sequential, CAS latency 2.
  localparam logic [11:0] MODE_WORD = 12'h020;

  // Column address with A[10] set so every access auto-precharges.
  function automatic logic [11:0] rw_addr(input logic [9:0] col);
    return {1'b0, 1'b1, col};
  endfunction

  function automatic cnt_t last_cnt(input int unsigned n);
    return cnt_t'(n - 1);
  endfunction

endpackage

// File: rtl/sdram_cmd_seq_phi2_edge.sv
// phi2_edge: brings the C64 PHI2 clock into the C25M domain through a
// 2-flop synchronizer and pulses o_fall for one cycle, one cycle after the
// synchronized level drops from 1 to 0.
module phi2_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_phi2,
  output logic o_fall
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync_d;
  logic r_fall;

  // Synchronizer, delayed copy and registered falling-edge flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync_d <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_sync1  <= i_phi2;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
      r_fall   <= r_sync_d & ~r_sync2;
    end
  end

  assign o_fall = r_fall;

endmodule

// File: rtl/sdram_cmd_seq.sv
// sdram_cmd_seq: single-access SDRAM command sequencer for a C64 REU.
// Latches a DMA request on each PHI2 falling edge, runs the SDRAM power-up
// sequence, serves one byte per access with auto-precharge and interleaves
// periodic auto-refresh.
// Build option: SDRAM_FASTINIT_EN selects the short power-up wait.
module sdram_cmd_seq
  import sdram_pkg::*;
(
  input  logic        C25M,
  input  logic        nRESET,
  input  logic        PHI2,
  input  logic        RAMRD,
  input  logic        RAMWR,
  input  logic [23:0] RA,
  input  logic [7:0]  WD,
  output logic [7:0]  RD,
  output logic        Busy,
  output logic        CKE,
  output logic        nCS,
  output logic        nRAS,
  output logic        nCAS,
  output logic        nWE,
  output logic [1:0]  BA,
  output logic [11:0] A,
  output logic        DQM,
  output logic [7:0]  DQout,
  output logic        DQoe,
  input  logic [7:0]  DQin
);

  localparam cnt_t WAIT_INIT_LAST = last_cnt(INIT_WAIT_CYCLES);
  localparam cnt_t PRE_LAST       = last_cnt(PRE_CYCLES);
  localparam cnt_t INIT_REF_LAST  = last_cnt(2 * REF_CYCLES);
  localparam cnt_t INIT_REF2      = cnt_t'(REF_CYCLES);
  localparam cnt_t MRS_LAST       = last_cnt(MRS_CYCLES);
  localparam cnt_t ACT_LAST       = last_cnt(ACT_CYCLES);
  localparam cnt_t WAIT_LAST      = last_cnt(WAIT_CYCLES);
  localparam cnt_t REF_LAST       = last_cnt(REF_CYCLES);
  // Data of a RD issued in the RW cycle is sampled CAS_LATENCY edges later.
  localparam cnt_t RD_CAPTURE     = cnt_t'(CAS_LATENCY - 2);
  localparam logic [7:0] REF_TC   = 8'(REF_INTERVAL - 1);

  state_t      r_state;
  state_t      w_next;
  cnt_t        r_cnt;
  cnt_t        w_cnt_next;
  logic        r_cke;

  logic        w_fall;
  logic        r_req_vld;
  logic        r_req_wr;
  logic [23:0] r_req_addr;
  logic [7:0]  r_req_wd;
  logic        r_cur_wr;
  logic [23:0] r_cur_addr;
  logic [7:0]  r_cur_wd;

  logic [7:0]  r_ref_cnt;
  logic        r_ref_pend;
  logic [7:0]  r_rd;

  cmd_t        w_cmd;
  logic [1:0]  w_ba;
  logic [11:0] w_a;
  logic        w_dqoe;
  logic [7:0]  w_dqout;
  logic        w_start;
  logic        w_ref_done;
  logic        w_in_init;

  phi2_edge u_phi2_edge (
    .i_clk   (C25M),
    .i_rst_n (nRESET),
    .i_phi2  (PHI2),
    .o_fall  (w_fall)
  );

  assign w_in_init = (r_state == INIT_WAIT) || (r_state == INIT_PRE) ||
                     (r_state == INIT_REF)  || (r_state == INIT_MRS);

  // Next state, cycle counter and SDRAM pin values decoded from the state.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt + cnt_t'(1);
    w_cmd      = CMD_NOP;
    w_ba       = '0;
    w_a        = '0;
    w_dqoe     = 1'b0;
    w_dqout    = '0;
    w_start    = 1'b0;
    w_ref_done = 1'b0;
    case (r_state)
      INIT_WAIT: begin
        if (r_cnt == WAIT_INIT_LAST) begin
          w_next     = INIT_PRE;
          w_cnt_next = '0;
        end
      end
      INIT_PRE: begin
        if (r_cnt == '0) begin
          w_cmd  = CMD_PRE;
          w_a[10] = 1'b1;
        end
        if (r_cnt == PRE_LAST) begin
          w_next     = INIT_REF;
          w_cnt_next = '0;
        end
      end
      INIT_REF: begin
        if (r_cnt == '0 || r_cnt == INIT_REF2) begin
          w_cmd = CMD_REF;
        end
        if (r_cnt == INIT_REF_LAST) begin
          w_next     = INIT_MRS;
          w_cnt_next = '0;
        end
      end
      INIT_MRS: begin
        if (r_cnt == '0) begin
          w_cmd = CMD_MRS;
          w_a   = MODE_WORD;
        end
        if (r_cnt == MRS_LAST) begin
          w_next     = IDLE;
          w_cnt_next = '0;
        end
      end
      IDLE: begin
        w_cnt_next = '0;
        if (r_req_vld) begin
          w_next  = ACT;
          w_start = 1'b1;
        end else if (r_ref_pend) begin
          w_next = REF;
        end
      end
      ACT: begin
        if (r_cnt == '0) begin
          w_cmd = CMD_ACT;
          w_ba  = r_cur_addr[23:22];
          w_a   = r_cur_addr[21:10];
        end
        if (r_cnt == ACT_LAST) begin
          w_next     = RW;
          w_cnt_next = '0;
        end
      end
      RW: begin
        w_cmd      = r_cur_wr ? CMD_WR : CMD_RD;
        w_ba       = r_cur_addr[23:22];
        w_a        = rw_addr(r_cur_addr[9:0]);
        w_dqoe     = r_cur_wr;
        w_dqout    = r_cur_wr ? r_cur_wd : '0;
        w_next     = WAIT;
        w_cnt_next = '0;
      end
      WAIT: begin
        if (r_cnt == WAIT_LAST) begin
          w_next     = IDLE;
          w_cnt_next = '0;
        end
      end
      REF: begin
        if (r_cnt == '0) begin
          w_cmd = CMD_REF;
        end
        if (r_cnt == REF_LAST) begin
          w_next     = IDLE;
          w_cnt_next = '0;
          w_ref_done = 1'b1;
        end
      end
      default: begin
        w_next     = INIT_WAIT;
        w_cnt_next = '0;
      end
    endcase
  end

  // State register, cycle counter and clock enable.
  always_ff @(posedge C25M or negedge nRESET) begin
    if (!nRESET) begin
      r_state <= INIT_WAIT;
      r_cnt   <= '0;
      r_cke   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_cke   <= 1'b1;
    end
  end

  // Pending request latch; a latch on the same edge as the access start
  // becomes the next pending request rather than being lost.
  always_ff @(posedge C25M or negedge nRESET) begin
    if (!nRESET) begin
      r_req_vld  <= 1'b0;
      r_req_wr   <= 1'b0;
      r_req_addr <= '0;
      r_req_wd   <= '0;
      r_cur_wr   <= 1'b0;
      r_cur_addr <= '0;
      r_cur_wd   <= '0;
    end else begin
      if (w_fall) begin
        r_req_vld  <= RAMRD | RAMWR;
        r_req_wr   <= RAMWR & ~RAMRD;
        r_req_addr <= RA;
        r_req_wd   <= WD;
      end else if (w_start) begin
        r_req_vld  <= 1'b0;
      end
      if (w_start) begin
        r_cur_wr   <= r_req_wr;
        r_cur_addr <= r_req_addr;
        r_cur_wd   <= r_req_wd;
      end
    end
  end

  // Refresh interval timer; a terminal count wins over the clear at REF end.
  always_ff @(posedge C25M or negedge nRESET) begin
    if (!nRESET) begin
      r_ref_cnt  <= '0;
      r_ref_pend <= 1'b0;
    end else if (w_in_init) begin
      r_ref_cnt  <= '0;
      r_ref_pend <= 1'b0;
    end else if (r_ref_cnt == REF_TC) begin
      r_ref_cnt  <= '0;
      r_ref_pend <= 1'b1;
    end else begin
      r_ref_cnt  <= r_ref_cnt + 8'd1;
      if (w_ref_done) begin
        r_ref_pend <= 1'b0;
      end
    end
  end

  // Read data capture, held until the next completed read.
  always_ff @(posedge C25M or negedge nRESET) begin
    if (!nRESET) begin
      r_rd <= '0;
    end else if (r_state == WAIT && r_cnt == RD_CAPTURE && !r_cur_wr) begin
      r_rd <= DQin;
    end
  end

  assign {nCS, nRAS, nCAS, nWE} = w_cmd;
  assign BA    = w_ba;
  assign A     = w_a;
  assign DQM   = 1'b0;
  assign DQoe  = w_dqoe;
  assign DQout = w_dqout;
  assign CKE   = r_cke;
  assign Busy  = (r_state != IDLE);
  assign RD    = r_rd;

endmodule

// File: tb/tb_sdram_cmd_seq.sv
// tb_sdram_cmd_seq: directed, table-driven bench for sdram_cmd_seq.
// Covers reset state, the power-up sequence, read/write accesses, the
// read-over-write rule, refresh/access collision and reset mid-access.
module tb_sdram_cmd_seq;

`ifdef SDRAM_FASTINIT_EN
  localparam int INIT_N = 16;
`else
  localparam int INIT_N = 2500;
`endif

  localparam logic [3:0] C_MRS = 4'b0000;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_NOP = 4'b0111;

  logic        C25M   = 1'b0;
  logic        nRESET = 1'b0;
  logic        PHI2   = 1'b1;
  logic        RAMRD  = 1'b0;
  logic        RAMWR  = 1'b0;
  logic [23:0] RA     = '0;
  logic [7:0]  WD     = '0;
  logic [7:0]  DQin   = 8'hEE;
  logic [7:0]  RD;
  logic        Busy, CKE, nCS, nRAS, nCAS, nWE, DQM, DQoe;
  logic [1:0]  BA;
  logic [11:0] A;
  logic [7:0]  DQout;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          last_ref = -1;
  bit          in_init  = 1'b1;
  logic [3:0]  cmd      = 4'b0111;
  logic [3:0]  prev_cmd = 4'b0111;
  logic [7:0]  mem_val  = '0;
  logic [7:0]  prev_rd  = '0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [23:0] ra;
    logic [7:0]  wd;
    logic [7:0]  dq;
    logic [3:0]  exp_cmd;
    logic [1:0]  exp_ba;
    logic [11:0] exp_row;
    logic [11:0] exp_a;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs[6];

  sdram_cmd_seq dut (
    .C25M   (C25M),
    .nRESET (nRESET),
    .PHI2   (PHI2),
    .RAMRD  (RAMRD),
    .RAMWR  (RAMWR),
    .RA     (RA),
    .WD     (WD),
    .RD     (RD),
    .Busy   (Busy),
    .CKE    (CKE),
    .nCS    (nCS),
    .nRAS   (nRAS),
    .nCAS   (nCAS),
    .nWE    (nWE),
    .BA     (BA),
    .A      (A),
    .DQM    (DQM),
    .DQout  (DQout),
    .DQoe   (DQoe),
    .DQin   (DQin)
  );

  always #20 C25M = ~C25M;

  task automatic check_true(input string name, input bit ok,
                            input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic check_eq(input string name, input logic [31:0] act,
                          input logic [31:0] req);
    check_true(name, act == req, act, req);
  endtask

  // One C25M cycle: sample at the falling edge, track refresh spacing and
  // drive the SDRAM data model (data valid the cycle after a RD command).
  task automatic tick();
    @(negedge C25M);
    cyc++;
    cmd = {nCS, nRAS, nCAS, nWE};
    if (!Busy) in_init = 1'b0;
    if (cmd == C_REF && !in_init) begin
      if (last_ref >= 0)
        check_true("ref_gap", (cyc - last_ref) <= 204, cyc - last_ref, 204);
      last_ref = cyc;
    end
    DQin     = (prev_cmd == C_RD) ? mem_val : 8'hEE;
    prev_cmd = cmd;
  endtask

  // Called right after nRESET is released at a falling clock edge.
  task automatic check_init();
    int         ev_cyc[$];
    logic [3:0] ev_cmd[$];
    logic [11:0] ev_a[$];
    logic [1:0] ev_ba[$];
    int         exp_cyc[4];
    logic [3:0] exp_cmd[4];
    logic [11:0] a_tmp;
    int         busy_fall;
    busy_fall  = -1;
    exp_cyc[0] = INIT_N;     exp_cmd[0] = C_PRE;
    exp_cyc[1] = INIT_N + 2; exp_cmd[1] = C_REF;
    exp_cyc[2] = INIT_N + 5; exp_cmd[2] = C_REF;
    exp_cyc[3] = INIT_N + 8; exp_cmd[3] = C_MRS;
    #1;
    check_eq("init_cke_cycle0", CKE, 0);
    for (int k = 1; k <= INIT_N + 20 && busy_fall < 0; k++) begin
      tick();
      if (k == 1) check_eq("init_cke_cycle1", CKE, 1);
      if (cmd != C_NOP) begin
        ev_cyc.push_back(k);
        ev_cmd.push_back(cmd);
        ev_a.push_back(A);
        ev_ba.push_back(BA);
      end
      if (!Busy) busy_fall = k;
    end
    check_eq("init_cmd_count", ev_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < ev_cyc.size()) begin
        check_eq("init_cmd_cycle", ev_cyc[i], exp_cyc[i]);
        check_eq("init_cmd_code", ev_cmd[i], exp_cmd[i]);
      end
    end
    if (ev_cyc.size() >= 4) begin
      a_tmp = ev_a[0];
      check_eq("init_pre_a10", a_tmp[10], 1);
      check_eq("init_mrs_a", ev_a[3], 12'h020);
      check_eq("init_mrs_ba", ev_ba[3], 0);
    end
    check_eq("init_busy_fall", busy_fall, INIT_N + 11);
  endtask

  task automatic run_vec(input vec_t v);
    int          act_c, rw_c, oe_cnt, oe_c, rw_count;
    logic [1:0]  act_ba, rw_ba;
    logic [11:0] act_a, rw_a;
    logic [3:0]  rw_cmd;
    logic [7:0]  oe_d, rd_p1, rd_p2;
    logic        busy5, busy6;
    act_c = -1; rw_c = -1; oe_cnt = 0; oe_c = -1; rw_count = 0;
    act_ba = '0; rw_ba = '0; act_a = '0; rw_a = '0; rw_cmd = C_NOP;
    oe_d = '0; rd_p1 = '0; rd_p2 = '0; busy5 = 1'b0; busy6 = 1'b1;
    mem_val = v.dq;
    RAMRD = v.rd; RAMWR = v.wr; RA = v.ra; WD = v.wd; PHI2 = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 8) begin
        PHI2 = 1'b1; RAMRD = 1'b0; RAMWR = 1'b0; RA = '0; WD = '0;
      end
      if (cmd == C_ACT && act_c < 0) begin
        act_c = k; act_ba = BA; act_a = A;
      end
      if (cmd == C_RD || cmd == C_WR) begin
        rw_count++;
        if (rw_c < 0) begin
          rw_c = k; rw_cmd = cmd; rw_ba = BA; rw_a = A;
        end
      end
      if (DQoe) begin
        oe_cnt++; oe_c = k; oe_d = DQout;
      end
      if (rw_c > 0 && k == rw_c + 1) rd_p1 = RD;
      if (rw_c > 0 && k == rw_c + 2) rd_p2 = RD;
      if (act_c > 0 && k == act_c + 5) busy5 = Busy;
      if (act_c > 0 && k == act_c + 6) busy6 = Busy;
    end
    if (v.exp_cmd == C_NOP) begin
      check_true("noreq_no_act", act_c < 0, act_c, 32'hFFFFFFFF);
      check_eq("noreq_no_rw", rw_count, 0);
    end else begin
      check_true("act_seen", act_c > 0, act_c, 1);
      check_eq("act_ba", act_ba, v.exp_ba);
      check_eq("act_row", act_a, v.exp_row);
      check_eq("act_to_rw", rw_c - act_c, 2);
      check_eq("rw_cmd", rw_cmd, v.exp_cmd);
      check_eq("rw_count", rw_count, 1);
      check_eq("rw_ba", rw_ba, v.exp_ba);
      check_eq("rw_a", rw_a, v.exp_a);
      check_eq("dqoe_cycles", oe_cnt, (v.exp_cmd == C_WR) ? 1 : 0);
      if (v.exp_cmd == C_WR) begin
        check_eq("dqoe_in_wr_cycle", oe_c, rw_c);
        check_eq("dqout", oe_d, v.wd);
      end else begin
        check_eq("rd_before_cl", rd_p1, prev_rd);
        check_eq("rd_at_cl", rd_p2, v.exp_rd);
      end
      check_eq("busy_last_access_cycle", busy5, 1);
      check_eq("busy_idle_after_access", busy6, 0);
    end
    check_eq("rd_held", RD, v.exp_rd);
    prev_rd = v.exp_rd;
  endtask

  initial begin : main
    int c_ref, act_c, ref_c, w_c, bad_hold;

    vecs[0] = '{1'b0, 1'b1, 24'hC01234, 8'h5A, 8'h00, C_WR,  2'd3, 12'h004, 12'h634, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 24'hC01234, 8'h00, 8'h5A, C_RD,  2'd3, 12'h004, 12'h634, 8'h5A};
    vecs[2] = '{1'b1, 1'b1, 24'h012345, 8'hA5, 8'h3C, C_RD,  2'd0, 12'h048, 12'h745, 8'h3C};
    vecs[3] = '{1'b0, 1'b1, 24'h7FFFFF, 8'hFF, 8'h00, C_WR,  2'd1, 12'hFFF, 12'h7FF, 8'h3C};
    vecs[4] = '{1'b1, 1'b0, 24'h400000, 8'h00, 8'h81, C_RD,  2'd1, 12'h000, 12'h400, 8'h81};
    vecs[5] = '{1'b0, 1'b0, 24'h123456, 8'h11, 8'h00, C_NOP, 2'd0, 12'h000, 12'h000, 8'h81};

    // Reset state.
    repeat (3) tick();
    check_eq("rst_cke", CKE, 0);
    check_eq("rst_cmd", cmd, C_NOP);
    check_eq("rst_busy", Busy, 1);
    check_eq("rst_ba", BA, 0);
    check_eq("rst_a", A, 0);
    check_eq("rst_dqoe", DQoe, 0);
    check_eq("rst_dqout", DQout, 0);
    check_eq("rst_rd", RD, 0);
    check_eq("rst_dqm", DQM, 0);
    nRESET = 1'b1;
    check_init();

    // Table of single accesses.
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Refresh terminal count on the same cycle a request becomes pending.
    c_ref = -1;
    for (int k = 0; k < 400 && c_ref < 0; k++) begin
      tick();
      if (cmd == C_REF) c_ref = cyc;
    end
    check_true("periodic_ref_seen", c_ref >= 0, c_ref, 1);
    if (c_ref >= 0) begin
      while (cyc < c_ref + 190) tick();
      RAMWR = 1'b1; RA = 24'h000400; WD = 8'h33; PHI2 = 1'b0;
      act_c = -1; ref_c = -1;
      for (int k = 1; k <= 30; k++) begin
        tick();
        if (k == 8) begin PHI2 = 1'b1; RAMWR = 1'b0; end
        if (cmd == C_ACT && act_c < 0) act_c = cyc;
        if (cmd == C_REF && ref_c < 0) ref_c = cyc;
      end
      check_eq("coincide_act_cycle", act_c - c_ref, 195);
      check_eq("coincide_ref_cycle", ref_c - c_ref, 202);
    end

    // Reset pulsed during the RW cycle of a write.
    mem_val = '0;
    RAMWR = 1'b1; RA = 24'h2AAAAA; WD = 8'hC3; PHI2 = 1'b0;
    w_c = -1;
    for (int k = 1; k <= 30 && w_c < 0; k++) begin
      tick();
      if (k == 8) begin PHI2 = 1'b1; RAMWR = 1'b0; end
      if (cmd == C_WR) w_c = k;
    end
    PHI2 = 1'b1; RAMWR = 1'b0;
    check_true("midrw_reached_wr", w_c > 0, w_c, 1);
    nRESET = 1'b0; in_init = 1'b1; last_ref = -1;
    #1;
    check_eq("midrw_cke", CKE, 0);
    check_eq("midrw_cmd", {nCS, nRAS, nCAS, nWE}, C_NOP);
    check_eq("midrw_busy", Busy, 1);
    check_eq("midrw_dqoe", DQoe, 0);
    check_eq("midrw_dqout", DQout, 0);
    check_eq("midrw_a", A, 0);
    check_eq("midrw_ba", BA, 0);
    check_eq("midrw_rd", RD, 0);
    bad_hold = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (cmd != C_NOP || CKE != 1'b0) bad_hold++;
    end
    check_eq("midrw_hold_quiet", bad_hold, 0);
    prev_cmd = C_NOP;
    prev_rd  = '0;
    nRESET = 1'b1;
    check_init();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
